// File: rtl/rx_pkg.sv
// Shared definitions for the UART rx path: deserializer state encoding and
// the default word/block geometry used by both the deserializer and the rx block buffer.
package rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } rx_state_e;

  localparam int unsigned RX_BYTE_W = 8;
  localparam int unsigned RX_NBYTES = 16;

endpackage

// File: rtl/rx_idle_timer.sv
// Idle-cycle timer: clears on i_clear, counts while i_count, pulses o_expire
// combinationally on the cycle the count would reach LIMIT.
module rx_idle_timer #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int unsigned TW = $clog2(LIMIT + 1);

  logic [TW-1:0] r_count;

  assign o_expire = i_count && !i_clear && (r_count == TW'(LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + TW'(1);
    end
  end

endmodule

// File: rtl/rx_block_deser.sv
// Byte-to-block deserializer with ready/valid output and overrun flag.
// Define RX_BLOCK_DESER_TIMEOUT_EN to flush partial blocks after TIMEOUT_CYC idle cycles.
module rx_block_deser
  import rx_pkg::*;
#(
  parameter int unsigned BYTE_W      = RX_BYTE_W,
  parameter int unsigned NBYTES      = RX_NBYTES,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        din,
  input  logic                     din_valid,
  output logic [BYTE_W*NBYTES-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] CntLast = CW'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > 256) begin : g_bad_nbytes
    $error("rx_block_deser: NBYTES must be in 1..256");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("rx_block_deser: TIMEOUT_CYC must be at least 1");
  end

  rx_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sr;
  logic          r_dout_valid;
  logic          r_overrun;
  logic          r_timeout;

  logic [W-1:0]  w_sr_shift;
  logic [W-1:0]  w_sr_load;
  logic          w_expire;

  // w_sr_load starts a fresh block; stale words are pushed out before it completes.
  if (NBYTES == 1) begin : g_one
    assign w_sr_shift = din;
    assign w_sr_load  = din;
  end else if (MSB_FIRST) begin : g_msb
    assign w_sr_shift = {r_sr[W-BYTE_W-1:0], din};
    assign w_sr_load  = {{(W - BYTE_W){1'b0}}, din};
  end else begin : g_lsb
    assign w_sr_shift = {din, r_sr[W-1:BYTE_W]};
    assign w_sr_load  = {din, {(W - BYTE_W){1'b0}}};
  end

`ifdef RX_BLOCK_DESER_TIMEOUT_EN
  rx_idle_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_idle_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (din_valid || (r_state != ST_FILL)),
    .i_count  (r_state == ST_FILL),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_sr         <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (din_valid) begin
            r_sr  <= w_sr_load;
            r_cnt <= CW'(1);
            if (NBYTES == 1) begin
              r_state      <= ST_HOLD;
              r_dout_valid <= 1'b1;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (din_valid) begin
            r_sr  <= w_sr_shift;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CntLast) begin
              r_state      <= ST_HOLD;
              r_dout_valid <= 1'b1;
            end
          end else if (w_expire) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (dout_ready) begin
            if (din_valid) begin
              r_sr  <= w_sr_load;
              r_cnt <= CW'(1);
              if (NBYTES == 1) begin
                r_dout_valid <= 1'b1;
              end else begin
                r_state      <= ST_FILL;
                r_dout_valid <= 1'b0;
              end
            end else begin
              r_state      <= ST_IDLE;
              r_cnt        <= '0;
              r_dout_valid <= 1'b0;
            end
          end else if (din_valid) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The shift register is frozen in HOLD, so it serves directly as the block output.
  assign dout       = r_sr;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == ST_FILL);
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rx_block_deser.sv
// Scoreboard bench for rx_block_deser: MSB-first and LSB-first instances share one stimulus.
// Timeout checks follow RX_BLOCK_DESER_TIMEOUT_EN when the bench is built with it.
module tb_rx_block_deser;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   din;
  logic         din_valid;
  logic         dout_ready;
  logic [127:0] dout_m, dout_l;
  logic         dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l, to_m, to_l;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  int unsigned  n_ovr    = 0;
  int unsigned  n_to     = 0;

  logic [7:0]   pend[$];
  logic [127:0] q_m[$];
  logic [127:0] q_l[$];

  always #5 clk = ~clk;

  rx_block_deser #(
    .BYTE_W      (8),
    .NBYTES      (16),
    .MSB_FIRST   (1'b1),
    .TIMEOUT_CYC (20)
  ) dut_m (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout_m),
    .dout_valid (dv_m),
    .dout_ready (dout_ready),
    .busy       (busy_m),
    .overrun    (ovr_m),
    .timeout    (to_m)
  );

  rx_block_deser #(
    .BYTE_W      (8),
    .NBYTES      (16),
    .MSB_FIRST   (1'b0),
    .TIMEOUT_CYC (20)
  ) dut_l (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout_l),
    .dout_valid (dv_l),
    .dout_ready (dout_ready),
    .busy       (busy_l),
    .overrun    (ovr_l),
    .timeout    (to_l)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Accepted word: once 16 are collected, queue the expected block for each ordering.
  task automatic model_accept(input logic [7:0] w);
    logic [127:0] em, el;
    pend.push_back(w);
    if (pend.size() == 16) begin
      em = '0;
      el = '0;
      for (int k = 0; k < 16; k++) begin
        em[(15 - k) * 8 +: 8] = pend[k];
        el[k * 8 +: 8]        = pend[k];
      end
      q_m.push_back(em);
      q_l.push_back(el);
      pend.delete();
    end
  endtask

  task automatic send(input logic [7:0] w, input bit dropped);
    din       = w;
    din_valid = 1'b1;
    if (!dropped) model_accept(w);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (dv_m && dout_ready) begin
      if (q_m.size() == 0) check_eq("unexpected_blk_m", 1'b1, 1'b0);
      else check_eq("blk_m", dout_m, q_m.pop_front());
    end
    if (dv_l && dout_ready) begin
      if (q_l.size() == 0) check_eq("unexpected_blk_l", 1'b1, 1'b0);
      else check_eq("blk_l", dout_l, q_l.pop_front());
    end
    if (ovr_m) n_ovr++;
    if (to_m) n_to++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_dout", dout_m, '0);
    check_eq("rst_valid", {dv_m, dv_l}, 2'b00);
    check_eq("rst_busy", {busy_m, busy_l}, 2'b00);
    check_eq("rst_flags", {ovr_m, to_m}, 2'b00);
    reset = 1'b0;
    tick();

    // Ascending words, ready high; busy spans words 1..15, valid right after word 16.
    check_eq("t1_busy_pre", busy_l, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      if (i < 15) check_eq("t2_busy_fill", {busy_m, busy_l}, 2'b11);
    end
    check_eq("t1_valid_after_last", {dv_m, dv_l}, 2'b11);
    check_eq("t2_busy_hold", busy_l, 1'b0);
    tick();
    check_eq("t1_valid_one_cycle", {dv_m, dv_l}, 2'b00);

    // Held block with three dropped words.
    dout_ready = 1'b0;
    n_ovr      = 0;
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
    check_eq("t3_valid", dv_m, 1'b1);
    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 1'b1);
    tick();
    check_eq("t3_overruns", 32'(n_ovr), 32'd3);
    check_eq("t3_still_valid", dv_m, 1'b1);
    dout_ready = 1'b1;
    tick();
    check_eq("t3_idle_valid", dv_m, 1'b0);
    check_eq("t3_idle_busy", busy_m, 1'b0);

    // Handshake and a new word in the same cycle.
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
    dout_ready = 1'b1;
    send(8'hAA, 1'b0);
    check_eq("t4_valid_drop", dv_m, 1'b0);
    check_eq("t4_busy_new", busy_m, 1'b1);
    for (int i = 0; i < 15; i++) send(8'(8'h60 + i), 1'b0);
    check_eq("t4_valid", dv_m, 1'b1);
    tick();

    // Reset mid-fill.
    for (int i = 0; i < 7; i++) send(8'(8'h70 + i), 1'b0);
    reset = 1'b1;
    tick();
    check_eq("t5_rst_dout", {dout_m, dout_l} == '0, 1'b1);
    check_eq("t5_rst_outs", {dv_m, busy_m, ovr_m, to_m, dv_l, busy_l}, 6'b0);
    tick();
    reset = 1'b0;
    pend.delete();
    for (int i = 0; i < 16; i++) send(8'(8'h90 + i), 1'b0);
    tick();

    // Stalled partial block.
    n_to = 0;
    for (int i = 0; i < 5; i++) send(8'(8'hB0 + i), 1'b0);
`ifdef RX_BLOCK_DESER_TIMEOUT_EN
    repeat (19) tick();
    check_eq("t6_no_early_to", to_m, 1'b0);
    check_eq("t6_busy_wait", busy_m, 1'b1);
    tick();
    check_eq("t6_to_pulse", {to_m, to_l}, 2'b11);
    check_eq("t6_busy_flush", busy_m, 1'b0);
    pend.delete();
    tick();
    check_eq("t6_to_one_cycle", to_m, 1'b0);
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b0);
    check_eq("t6_valid", dv_m, 1'b1);
    tick();
    check_eq("t6_to_count", 32'(n_to), 32'd1);
`else
    repeat (25) tick();
    check_eq("t6_busy_wait", busy_m, 1'b1);
    for (int i = 5; i < 16; i++) send(8'(8'hB0 + i), 1'b0);
    check_eq("t6_valid", dv_m, 1'b1);
    tick();
    check_eq("t6_to_count", 32'(n_to), 32'd0);
`endif

    check_eq("end_q_m_empty", 32'(q_m.size()), 32'd0);
    check_eq("end_q_l_empty", 32'(q_l.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
